// File: rtl/led_pkg.sv
// led_pkg: mode codes and the mode width shared by the LED pattern generator.
package led_pkg;
  localparam int MODE_W = 3;
  typedef enum logic [MODE_W-1:0] {
    MODE_OFF      = 3'd0,
    MODE_LEFT     = 3'd1,
    MODE_RIGHT    = 3'd2,
    MODE_DIVERGE  = 3'd3,
    MODE_CONVERGE = 3'd4
  } mode_t;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: forwards din to dout only once din has differed from dout for CNT consecutive clocks.
module key_debounce #(
  parameter int CNT = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);
  localparam int CW = $clog2(CNT);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dout_q, dout_d;
  logic          done;
  always_comb begin
    done   = (din != dout_q) && (cnt_q == CW'(CNT - 1));
    cnt_d  = (din == dout_q || done) ? '0 : cnt_q + 1'b1;
    dout_d = done ? din : dout_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      dout_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
    end
  end
  assign dout = dout_q;
endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: key-selected LED chaser (left/right/diverge/converge), active-low registered LEDs.
// Define LED_PATTERN_DEBOUNCE_EN to insert a key_debounce stage between synchroniser and press detector.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int LED_NUM      = 4,
  parameter int STEP_CNT     = 25_000_000,
  parameter int DEBOUNCE_CNT = 1_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         key,
  output logic [LED_NUM-1:0] led,
  output logic [MODE_W-1:0]  mode,
  output logic               step_tick
);
  localparam int CW   = $clog2(STEP_CNT);
  localparam int SW   = $clog2(LED_NUM);
  localparam int HALF = LED_NUM / 2;

  logic [3:0]         sync1_q, sync2_q, kin, prev_q, press;
  mode_t              mode_q, mode_d, mode_eff, sel;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [SW-1:0]      step_q, step_d;
  logic [LED_NUM-1:0] led_q, led_d, lit;
  logic               chg, tick, last;
  int                 s, k;

  if (LED_NUM < 2 || LED_NUM > 16 || LED_NUM % 2 != 0 || STEP_CNT < 2 || DEBOUNCE_CNT < 2) begin : g_bad_cfg
    $error("led_pattern_gen: illegal parameter set");
  end

`ifdef LED_PATTERN_DEBOUNCE_EN
  for (genvar i = 0; i < 4; i++) begin : g_db
    key_debounce #(.CNT(DEBOUNCE_CNT)) u_db (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (sync2_q[i]),
      .dout (kin[i])
    );
  end
`else
  assign kin = sync2_q;
`endif

  always_comb begin
    press    = prev_q & ~kin;
    mode_eff = (mode_q > MODE_CONVERGE) ? MODE_OFF : mode_q;
    sel      = press[0] ? MODE_LEFT : press[1] ? MODE_RIGHT : press[2] ? MODE_DIVERGE :
               press[3] ? MODE_CONVERGE : MODE_OFF;
    mode_d   = (|press) ? ((sel == mode_eff) ? MODE_OFF : sel) : mode_eff;
    chg      = mode_d != mode_q;
    tick     = (mode_eff != MODE_OFF) && (cnt_q == CW'(STEP_CNT - 1));
    last     = (mode_eff == MODE_LEFT || mode_eff == MODE_RIGHT) ? (step_q == SW'(LED_NUM - 1)) :
               (step_q == SW'(HALF));
    cnt_d    = (chg || mode_eff == MODE_OFF || tick) ? '0 : cnt_q + 1'b1;
    step_d   = (chg || (tick && last)) ? '0 : tick ? step_q + 1'b1 : step_q;
    s        = int'(step_q);
    // converge replays the diverge steps 1..HALF backwards
    k        = (mode_eff == MODE_DIVERGE) ? s : HALF + 1 - s;
    lit      = '0;
    for (int i = 0; i < LED_NUM; i++)
      lit[i] = (mode_eff == MODE_LEFT && i == s) ||
               (mode_eff == MODE_RIGHT && i == LED_NUM - 1 - s) ||
               ((mode_eff == MODE_DIVERGE || mode_eff == MODE_CONVERGE) && s != 0 &&
                (i == HALF - k || i == HALF - 1 + k));
    led_d    = ~lit;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
      prev_q  <= '1;
      mode_q  <= MODE_OFF;
      cnt_q   <= '0;
      step_q  <= '0;
      led_q   <= '1;
    end else begin
      sync1_q <= key;
      sync2_q <= sync1_q;
      prev_q  <= kin;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      led_q   <= led_d;
    end
  end

  assign led       = led_q;
  assign mode      = mode_q;
  assign step_tick = tick;
endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: directed checks of led_pattern_gen with LED_NUM=4, STEP_CNT=4, DEBOUNCE_CNT=3.
module tb_led_pattern_gen;
`ifdef LED_PATTERN_DEBOUNCE_EN
  localparam int LAT = 6;
  localparam int GLITCH_MODE = 0;
`else
  localparam int LAT = 3;
  localparam int GLITCH_MODE = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key;
  logic [3:0] led;
  logic [2:0] mode;
  logic       step_tick;
  logic [3:0] led_first;
  int         n_chk = 0, n_err = 0, since = 0, lat = -1, ticks;

  led_pattern_gen #(.LED_NUM(4), .STEP_CNT(4), .DEBOUNCE_CNT(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key      (key),
    .led      (led),
    .mode     (mode),
    .step_tick(step_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    since++;
  endtask

  task automatic wait_to(input int j);
    while (since < j) cyc();
  endtask

  // since counts negedges after the edge on which mode changed
  task automatic press(input logic [3:0] m, input int hold);
    logic [2:0] m0;
    bit         seen;
    m0 = mode;
    seen = 1'b0;
    lat = -1;
    led_first = 4'b0000;
    key = ~m;
    for (int i = 1; i <= 40; i++) begin
      cyc();
      if (!seen && mode != m0) begin
        seen = 1'b1;
        lat = i;
        since = 0;
      end
      if (i == hold) key = 4'b1111;
      if (seen && since == 1) led_first = led;
      if (i >= hold && seen && since >= 1) break;
    end
    key = 4'b1111;
  endtask

  initial begin
    rst_n = 1'b0;
    key = 4'b1111;
    repeat (3) cyc();
    chk("rst_led", led, 4'b1111);
    chk("rst_mode", mode, 0);
    chk("rst_tick", step_tick, 0);
    rst_n = 1'b1;
    ticks = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      ticks += int'(step_tick);
    end
    chk("idle_led", led, 4'b1111);
    chk("idle_mode", mode, 0);
    chk("idle_ticks", ticks, 0);

    press(4'b0001, 10);
    chk("left_lat", lat, LAT);
    chk("left_mode", mode, 1);
    chk("left_s0", led_first, 4'b1110);
    wait_to(8);  chk("left_s1", led, 4'b1101);
    wait_to(12); chk("left_s2", led, 4'b1011);
    wait_to(16); chk("left_s3", led, 4'b0111);
    wait_to(19); chk("left_tick_hi", step_tick, 1);
    wait_to(20); chk("left_wrap", led, 4'b1110);
    chk("left_tick_lo", step_tick, 0);

    press(4'b0100, 2);
    chk("div_lat", lat, LAT);
    chk("div_mode", mode, 3);
    chk("div_s0", led_first, 4'b1111);
    wait_to(8);  chk("div_s1", led, 4'b1001);
    wait_to(12); chk("div_s2", led, 4'b0110);
    wait_to(16); chk("div_wrap", led, 4'b1111);
    wait_to(20); chk("div_s1b", led, 4'b1001);
    press(4'b0100, 2);
    chk("div_off_mode", mode, 0);
    chk("div_off_led", led_first, 4'b1111);
    wait_to(10); chk("off_hold", led, 4'b1111);

    press(4'b1010, 2);
    chk("simul_lat", lat, LAT);
    chk("simul_mode", mode, 2);
    chk("right_s0", led_first, 4'b0111);
    wait_to(8);  chk("right_s1", led, 4'b1011);

    press(4'b1000, 2);
    chk("conv_mode", mode, 4);
    chk("conv_s0", led_first, 4'b1111);
    wait_to(8);  chk("conv_s1", led, 4'b0110);
    wait_to(12); chk("conv_s2", led, 4'b1001);
    wait_to(14);
    rst_n = 1'b0;
    cyc();
    chk("midrst_led", led, 4'b1111);
    chk("midrst_mode", mode, 0);
    chk("midrst_tick", step_tick, 0);
    cyc();
    rst_n = 1'b1;
    repeat (8) cyc();
    chk("rel_mode", mode, 0);
    chk("rel_led", led, 4'b1111);

    press(4'b0001, 2);
    chk("glitch_mode", mode, GLITCH_MODE);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
